// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MIPS multiply/divide sequencer that owns HI/LO
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   startE, opE          start MULT(00)/MULTU(01)/DIV(10)/DIVU(11) from execute
//   srcaE, srcbE         rs (multiplicand/dividend), rt (multiplier/divisor)
//   flushE               execute stage flushed; aborts a running operation
//   hiweE, loweE, wdataE MTHI/MTLO write port (accepted only in IDLE)
//   stallE               stall request to the hazard unit
//   busy                 sequencer not idle
//   hi, lo               HI/LO registers, feed MFHI/MFLO
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    input  logic             hiweE,
    input  logic             loweE,
    input  logic [WIDTH-1:0] wdataE,
    output logic             stallE,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d, raw_q, raw_d, hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic               go, sgn, sa, sb, qbit;
    logic [WIDTH-1:0]   ma, mb, quo, rem, res_hi, res_lo;
    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] step, prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            m_q     <= '0;
            raw_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            raw_q   <= raw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        go      = (state_q == IDLE) && startE && !flushE;
        state_d = (state_q == IDLE) ? (go ? RUN : IDLE) :
                  (state_q == RUN)  ? (flushE ? IDLE : (cnt_q == CW'(1)) ? DONE : RUN) :
                  IDLE;
    end

    always_comb begin
        stallE = go || (state_q == RUN);
        busy   = state_q != IDLE;
        hi     = hi_q;
        lo     = lo_q;
    end

    // Signed ops run on magnitudes; signs are reapplied at commit.
    // p_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        sgn     = !opE[0];
        sa      = sgn & srcaE[WIDTH-1];
        sb      = sgn & srcbE[WIDTH-1];
        ma      = sa ? -srcaE : srcaE;
        mb      = sb ? -srcbE : srcbE;
        mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        rem_sh  = p_q[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, m_q};
        qbit    = !diff[WIDTH];
        step    = div_q ? {qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], qbit}
                        : {mul_sum, p_q[WIDTH-1:1]};
        prod    = neg_q ? -p_q : p_q;
        quo     = p_q[WIDTH-1:0];
        rem     = p_q[2*WIDTH-1:WIDTH];
        // Divide by zero: quotient all ones, remainder is the raw dividend.
        res_hi  = div_q ? (dz_q ? raw_q : rneg_q ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
        res_lo  = div_q ? (dz_q ? '1 : neg_q ? -quo : quo) : prod[WIDTH-1:0];
        p_d     = p_q;
        m_d     = m_q;
        raw_d   = raw_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (go) begin
            div_d  = opE[1];
            p_d    = {{WIDTH{1'b0}}, opE[1] ? ma : mb};
            m_d    = opE[1] ? mb : ma;
            raw_d  = srcaE;
            cnt_d  = CW'(WIDTH);
            neg_d  = sa ^ sb;
            rneg_d = sa;
            dz_d   = srcbE == '0;
        end
        if (state_q == RUN) begin
            p_d   = step;
            cnt_d = cnt_q - CW'(1);
        end
        if (state_q == DONE) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end else if (state_q == IDLE && !flushE) begin
            hi_d = hiweE ? wdataE : hi_q;
            lo_d = loweE ? wdataE : lo_q;
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startE = 1'b0;
    logic [1:0]  opE = 2'b00;
    logic [31:0] srcaE = '0;
    logic [31:0] srcbE = '0;
    logic        flushE = 1'b0;
    logic        hiweE = 1'b0;
    logic        loweE = 1'b0;
    logic [31:0] wdataE = '0;
    logic        stallE, busy;
    logic [31:0] hi, lo;
    int          total = 0;
    int          bad = 0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
        .flushE(flushE), .hiweE(hiweE), .loweE(loweE), .wdataE(wdataE),
        .stallE(stallE), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Entered just after a falling edge with the unit idle; holds startE for the
    // whole stall like a real pipeline, drops it in DONE, then checks HI/LO.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string tag);
        int n = 0;
        startE = 1'b1;
        opE = op;
        srcaE = a;
        srcbE = b;
        #1;
        while (stallE && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, " stall"}, 64'(n), 64'd33);
        check({tag, " done busy"}, 64'(busy), 64'd1);
        startE = 1'b0;
        @(negedge clk);
        #1;
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
        check({tag, " idle busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset stall", 64'(stallE), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max");
        run_op(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult -3*5");
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu 100/7");
        run_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, "divu 5/0");
        run_op(2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, "div -5/0");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "div minneg/-1");
        // back-to-back: the second start lands in the cycle right after DONE
        run_op(2'b00, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, "b2b mult");
        run_op(2'b10, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, "b2b div");

        // MTHI / MTLO in IDLE
        hiweE = 1'b1;
        wdataE = 32'h11;
        @(negedge clk);
        #1;
        hiweE = 1'b0;
        loweE = 1'b1;
        wdataE = 32'h22;
        @(negedge clk);
        #1;
        loweE = 1'b0;
        check("mthi", 64'(hi), 64'h11);
        check("mtlo", 64'(lo), 64'h22);

        // flush at RUN cycle 10
        startE = 1'b1;
        opE = 2'b01;
        srcaE = 32'd3;
        srcbE = 32'd4;
        for (int i = 0; i < 10; i++) @(negedge clk);
        #1;
        check("flush run busy", 64'(busy), 64'd1);
        startE = 1'b0;
        flushE = 1'b1;
        @(negedge clk);
        #1;
        flushE = 1'b0;
        #1;
        check("flush busy", 64'(busy), 64'd0);
        check("flush stall", 64'(stallE), 64'd0);
        check("flush hi", 64'(hi), 64'h11);
        check("flush lo", 64'(lo), 64'h22);

        // MTLO in IDLE
        loweE = 1'b1;
        wdataE = 32'hABCD;
        @(negedge clk);
        #1;
        loweE = 1'b0;
        check("mtlo abcd", 64'(lo), 64'hABCD);

        // MTHI during RUN is ignored
        startE = 1'b1;
        @(negedge clk);
        #1;
        hiweE = 1'b1;
        wdataE = 32'hDEAD;
        @(negedge clk);
        #1;
        hiweE = 1'b0;
        check("mthi in run", 64'(hi), 64'h11);

        // async reset mid-RUN
        startE = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        check("rst stall", 64'(stallE), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "after rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
